// File: rtl/spi_burst_slave_if.sv
// SPI burst slave bus: serial lines, RAM port and status.
// slave modport faces the DUT; master faces host/RAM side.
interface spi_burst_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  SS_n;
  logic                  MOSI;
  logic                  MISO;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  abort;

  modport slave (
    input  SS_n, MOSI, mem_rdata,
    output MISO, mem_addr, mem_wdata,
    output mem_we, mem_re, busy, abort
  );

  modport master (
    output SS_n, MOSI, mem_rdata,
    input  MISO, mem_addr, mem_wdata,
    input  mem_we, mem_re, busy, abort
  );
endinterface

// File: rtl/spi_burst_slave.sv
// SPI slave: cmd bit, address, burst of words to/from a sync RAM.
// Ports: clk, rst (async high), bus (slave modport: SPI + RAM + status).
module spi_burst_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic             clk,
  input  logic             rst,
  spi_burst_slave_if.slave bus
);
  localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ?
                      ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [CW-1:0] A_END = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_END = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] D_PRE = CW'(DATA_WIDTH - 2);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RD_WAIT, RDATA
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [SW-2:0]         sh, sh_n;
  logic [DATA_WIDTH-2:0] tx, tx_n;
  logic                  rd, rd_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DATA_WIDTH-1:0] wdata, wdata_n;
  logic                  we, we_n;
  logic                  re, re_n;
  logic                  miso, miso_n;
  logic                  abrt, abrt_n;
  logic                  busy_q;
  logic [SW-1:0]         shifted;
  logic [CW-1:0]         nb;
  logic [ADDR_WIDTH-1:0] addr_inc;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sh_n     = sh;
    tx_n     = tx;
    rd_n     = rd;
    addr_n   = addr;
    wdata_n  = wdata;
    we_n     = 1'b0;
    re_n     = 1'b0;
    miso_n   = 1'b0;
    abrt_n   = 1'b0;
    nb       = '0;
    shifted  = {sh, bus.MOSI};
    addr_inc = (addr == LAST) ? '0 : addr + 1'b1;
    if (state != IDLE && bus.SS_n) begin
      state_n = IDLE;
      cnt_n   = '0;
      abrt_n  = (state == CMD) || (state == ADDR) ||
                (state == WDATA && cnt != '0);
    end else begin
      unique case (state)
        IDLE: if (!bus.SS_n) state_n = CMD;
        CMD: begin
          rd_n    = bus.MOSI;
          cnt_n   = '0;
          state_n = ADDR;
        end
        ADDR: begin
          sh_n  = shifted[SW-2:0];
          cnt_n = cnt + 1'b1;
          if (cnt == A_END) begin
            addr_n = shifted[ADDR_WIDTH-1:0];
            cnt_n  = '0;
            if (rd) begin
              state_n = RD_WAIT;
              re_n    = 1'b1;
            end else begin
              state_n = WDATA;
            end
          end
        end
        WDATA: begin
          sh_n  = shifted[SW-2:0];
          cnt_n = cnt + 1'b1;
          // the strobe issued last edge is done; step address
          if (we) addr_n = addr_inc;
          if (cnt == D_END) begin
            we_n    = 1'b1;
            wdata_n = shifted[DATA_WIDTH-1:0];
            cnt_n   = '0;
          end
        end
        RD_WAIT: begin
          cnt_n = cnt + 1'b1;
          if (cnt != '0) begin
            tx_n    = bus.mem_rdata[DATA_WIDTH-2:0];
            miso_n  = bus.mem_rdata[DATA_WIDTH-1];
            cnt_n   = '0;
            state_n = RDATA;
            // 2-bit words: the load edge already shows bit DW-2
            if (D_PRE == '0) begin
              addr_n = addr_inc;
              re_n   = 1'b1;
            end
          end
        end
        RDATA: begin
          if (cnt == D_END) begin
            tx_n   = bus.mem_rdata[DATA_WIDTH-2:0];
            miso_n = bus.mem_rdata[DATA_WIDTH-1];
            cnt_n  = '0;
          end else begin
            tx_n   = tx << 1;
            miso_n = tx[DATA_WIDTH-2];
            cnt_n  = cnt + 1'b1;
            nb     = cnt + 1'b1;
          end
          // prefetch so the next word lands on the load edge
          if (nb == D_PRE) begin
            addr_n = addr_inc;
            re_n   = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sh     <= '0;
      tx     <= '0;
      rd     <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      we     <= 1'b0;
      re     <= 1'b0;
      miso   <= 1'b0;
      abrt   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      tx     <= tx_n;
      rd     <= rd_n;
      addr   <= addr_n;
      wdata  <= wdata_n;
      we     <= we_n;
      re     <= re_n;
      miso   <= miso_n;
      abrt   <= abrt_n;
      busy_q <= (state_n != IDLE);
    end
  end

  assign bus.MISO      = miso;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_we    = we;
  assign bus.mem_re    = re;
  assign bus.busy      = busy_q;
  assign bus.abort     = abrt;
endmodule

// File: tb/tb_spi_burst_slave.sv
// Bench for spi_burst_slave: default and 10/16/1000 instances,
// RAM models, captured strobes checked against expected queues.
module tb_spi_burst_slave;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  spi_burst_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if0 ();
  spi_burst_slave_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) if1 ();

  spi_burst_slave #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256)
  ) u0 (.clk(clk), .rst(rst), .bus(if0));

  spi_burst_slave #(
    .ADDR_WIDTH(10), .DATA_WIDTH(16), .MEM_DEPTH(1000)
  ) u1 (.clk(clk), .rst(rst), .bus(if1));

  logic [7:0]  ram0 [256];
  logic [15:0] ram1 [1024];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_a = '0;
  logic [7:0]  pre_d = '0;

  always @(posedge clk) begin
    if (pre_en) ram0[pre_a] <= pre_d;
    if (if0.mem_we) ram0[if0.mem_addr] <= if0.mem_wdata;
    if (if0.mem_re) if0.mem_rdata <= ram0[if0.mem_addr];
    if (if1.mem_we) ram1[if1.mem_addr] <= if1.mem_wdata;
    if (if1.mem_re) if1.mem_rdata <= ram1[if1.mem_addr];
  end

  logic [31:0] cap_w0[$];
  logic [31:0] cap_r0[$];
  logic [31:0] cap_w1[$];
  logic [31:0] cap_r1[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (if0.mem_we)
        cap_w0.push_back(32'({if0.mem_addr, if0.mem_wdata}));
      if (if0.mem_re) cap_r0.push_back(32'(if0.mem_addr));
      if (if1.mem_we)
        cap_w1.push_back(32'({if1.mem_addr, if1.mem_wdata}));
      if (if1.mem_re) cap_r1.push_back(32'(if1.mem_addr));
    end
  end

  task automatic cyc0(input logic ss, input logic mosi);
    if0.SS_n = ss;
    if0.MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input logic ss, input logic mosi);
    if1.SS_n = ss;
    if1.MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) cyc0(1'b0, v[i]);
  endtask

  task automatic send1(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) cyc1(1'b0, v[i]);
  endtask

  task automatic preload0(input logic [7:0] a, input logic [7:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_en = 1'b1;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [24:0] g0;
    logic [33:0] g1;
    g0 = {if0.MISO, if0.mem_we, if0.mem_re, if0.busy,
          if0.abort, if0.mem_addr, if0.mem_wdata};
    g1 = {if1.MISO, if1.mem_we, if1.mem_re, if1.busy,
          if1.abort, if1.mem_addr, if1.mem_wdata};
    checks++;
    if (g0 !== '0) begin
      fails++;
      $display("FAIL reset_dut0 got=%h exp=0", g0);
    end
    checks++;
    if (g1 !== '0) begin
      fails++;
      $display("FAIL reset_dut1 got=%h exp=0", g1);
    end
    rst = 1'b0;
    cyc0(1'b1, 1'b0);
  endtask

  task automatic test_write_burst;
    logic [31:0] exp[$];
    logic [31:0] e, g;
    logic [7:0]  d [3];
    logic [7:0]  a;
    d[0] = 8'h11;
    d[1] = 8'h22;
    d[2] = 8'h33;
    cap_w0.delete();
    cyc0(1'b0, 1'b1);
    checks++;
    if (if0.busy !== 1'b1) begin
      fails++;
      $display("FAIL wr_busy got=%b exp=1", if0.busy);
    end
    cyc0(1'b0, 1'b0);
    send0(32'hFE, 8);
    for (int n = 0; n < 3; n++) begin
      a = 8'((254 + n) % 256);
      exp.push_back({16'h0, a, d[n]});
      send0(32'(d[n]), 8);
    end
    cyc0(1'b1, 1'b0);
    checks++;
    if ({if0.abort, if0.busy} !== 2'b00) begin
      fails++;
      $display("FAIL wr_end got=%b exp=00",
               {if0.abort, if0.busy});
    end
    while (exp.size() > 0) begin
      e = exp.pop_front();
      checks++;
      if (cap_w0.size() == 0) begin
        fails++;
        $display("FAIL wr_burst got=none exp=%h", e);
      end else begin
        g = cap_w0.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL wr_burst got=%h exp=%h", g, e);
        end
      end
    end
    checks++;
    if (cap_w0.size() != 0) begin
      fails++;
      $display("FAIL wr_extra got=%0d exp=0", cap_w0.size());
    end
  endtask

  task automatic test_read_burst;
    logic        bits[$];
    logic [31:0] exp[$];
    logic [31:0] e, g;
    logic [15:0] w;
    logic        b;
    preload0(8'h73, 8'hA5);
    preload0(8'h74, 8'h3C);
    w = 16'hA53C;
    for (int k = 15; k >= 0; k--) bits.push_back(w[k]);
    exp.push_back(32'h73);
    exp.push_back(32'h74);
    exp.push_back(32'h75);
    cap_r0.delete();
    cyc0(1'b0, 1'($urandom));
    cyc0(1'b0, 1'b1);
    send0(32'h73, 8);
    cyc0(1'b0, 1'($urandom));
    checks++;
    if (if0.MISO !== 1'b0) begin
      fails++;
      $display("FAIL rd_early got=%b exp=0", if0.MISO);
    end
    for (int k = 0; k < 16; k++) begin
      cyc0(1'b0, 1'($urandom));
      b = bits.pop_front();
      checks++;
      if (if0.MISO !== b) begin
        fails++;
        $display("FAIL rd_bit%0d got=%b exp=%b", k, if0.MISO, b);
      end
    end
    cyc0(1'b1, 1'b0);
    checks++;
    if ({if0.MISO, if0.abort, if0.busy} !== 3'b000) begin
      fails++;
      $display("FAIL rd_end got=%b exp=000",
               {if0.MISO, if0.abort, if0.busy});
    end
    while (exp.size() > 0) begin
      e = exp.pop_front();
      checks++;
      if (cap_r0.size() == 0) begin
        fails++;
        $display("FAIL rd_re got=none exp=%h", e);
      end else begin
        g = cap_r0.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL rd_re got=%h exp=%h", g, e);
        end
      end
    end
  endtask

  task automatic test_abort;
    logic [31:0] g;
    cap_w0.delete();
    cyc0(1'b0, 1'b0);
    cyc0(1'b0, 1'b0);
    send0(32'h10, 8);
    send0(32'h16, 5);
    cyc0(1'b1, 1'b0);
    checks++;
    if ({if0.abort, if0.busy} !== 2'b10) begin
      fails++;
      $display("FAIL ab_data got=%b exp=10",
               {if0.abort, if0.busy});
    end
    checks++;
    if (if0.mem_addr !== 8'h10) begin
      fails++;
      $display("FAIL ab_addr got=%h exp=10", if0.mem_addr);
    end
    cyc0(1'b1, 1'b0);
    checks++;
    if (if0.abort !== 1'b0) begin
      fails++;
      $display("FAIL ab_pulse got=%b exp=0", if0.abort);
    end
    checks++;
    if (cap_w0.size() != 0) begin
      fails++;
      $display("FAIL ab_nowe got=%0d exp=0", cap_w0.size());
    end
    cyc0(1'b0, 1'b0);
    cyc0(1'b0, 1'b0);
    send0(32'h5, 3);
    cyc0(1'b1, 1'b0);
    checks++;
    if ({if0.abort, if0.mem_addr} !== {1'b1, 8'h10}) begin
      fails++;
      $display("FAIL ab_cmdaddr got=%h exp=110",
               {if0.abort, if0.mem_addr});
    end
    cyc0(1'b1, 1'b0);
    cyc0(1'b0, 1'b0);
    cyc0(1'b0, 1'b0);
    send0(32'h10, 8);
    send0(32'h5A, 8);
    cyc0(1'b1, 1'b0);
    checks++;
    if (if0.abort !== 1'b0) begin
      fails++;
      $display("FAIL ab_next got=%b exp=0", if0.abort);
    end
    checks++;
    if (cap_w0.size() != 1) begin
      fails++;
      $display("FAIL ab_next_we got=%0d exp=1", cap_w0.size());
    end else begin
      g = cap_w0.pop_front();
      if (g !== 32'h105A) begin
        fails++;
        $display("FAIL ab_next_we got=%h exp=105a", g);
      end
    end
  endtask

  task automatic test_reset_mid_read;
    cyc0(1'b0, 1'b0);
    cyc0(1'b0, 1'b1);
    send0(32'h73, 8);
    cyc0(1'b0, 1'b0);
    cyc0(1'b0, 1'b0);
    checks++;
    if (if0.MISO !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre got=%b exp=1", if0.MISO);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({if0.MISO, if0.busy, if0.mem_addr} !== 10'h0) begin
      fails++;
      $display("FAIL rst_async got=%h exp=0",
               {if0.MISO, if0.busy, if0.mem_addr});
    end
    cyc0(1'b1, 1'b0);
    rst = 1'b0;
    cyc0(1'b1, 1'b0);
    checks++;
    if ({if0.abort, if0.busy} !== 2'b00) begin
      fails++;
      $display("FAIL rst_noabort got=%b exp=00",
               {if0.abort, if0.busy});
    end
    cap_w0.delete();
    cap_r0.delete();
  endtask

  task automatic test_variant;
    logic [31:0] exp[$];
    logic        bits[$];
    logic [31:0] e, g, w;
    logic        b;
    cap_w1.delete();
    exp.push_back({6'h0, 10'd999, 16'hBEEF});
    exp.push_back({6'h0, 10'd0, 16'hCAFE});
    cyc1(1'b0, 1'b0);
    cyc1(1'b0, 1'b0);
    send1(32'd999, 10);
    send1(32'hBEEF, 16);
    send1(32'hCAFE, 16);
    cyc1(1'b1, 1'b0);
    while (exp.size() > 0) begin
      e = exp.pop_front();
      checks++;
      if (cap_w1.size() == 0) begin
        fails++;
        $display("FAIL var_wr got=none exp=%h", e);
      end else begin
        g = cap_w1.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL var_wr got=%h exp=%h", g, e);
        end
      end
    end
    cap_r1.delete();
    w = 32'hBEEFCAFE;
    for (int k = 31; k >= 0; k--) bits.push_back(w[k]);
    exp.push_back(32'd999);
    exp.push_back(32'd0);
    exp.push_back(32'd1);
    cyc1(1'b0, 1'b0);
    cyc1(1'b0, 1'b1);
    send1(32'd999, 10);
    cyc1(1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      cyc1(1'b0, 1'($urandom));
      b = bits.pop_front();
      checks++;
      if (if1.MISO !== b) begin
        fails++;
        $display("FAIL var_bit%0d got=%b exp=%b", k, if1.MISO, b);
      end
    end
    cyc1(1'b1, 1'b0);
    while (exp.size() > 0) begin
      e = exp.pop_front();
      checks++;
      if (cap_r1.size() == 0) begin
        fails++;
        $display("FAIL var_re got=none exp=%h", e);
      end else begin
        g = cap_r1.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL var_re got=%h exp=%h", g, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic        bits[$];
    logic [7:0]  w;
    logic [31:0] g;
    logic        b;
    cap_w0.delete();
    w = 8'h77;
    for (int k = 7; k >= 0; k--) bits.push_back(w[k]);
    cyc0(1'b0, 1'b0);
    cyc0(1'b0, 1'b0);
    send0(32'h40, 8);
    send0(32'(w), 8);
    cyc0(1'b1, 1'b0);
    cyc0(1'b0, 1'b0);
    cyc0(1'b0, 1'b1);
    send0(32'h40, 8);
    cyc0(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc0(1'b0, 1'($urandom));
      b = bits.pop_front();
      checks++;
      if (if0.MISO !== b) begin
        fails++;
        $display("FAIL b2b_bit%0d got=%b exp=%b", k, if0.MISO, b);
      end
    end
    cyc0(1'b1, 1'b0);
    checks++;
    if (cap_w0.size() != 1) begin
      fails++;
      $display("FAIL b2b_we got=%0d exp=1", cap_w0.size());
    end else begin
      g = cap_w0.pop_front();
      if (g !== 32'h4077) begin
        fails++;
        $display("FAIL b2b_we got=%h exp=4077", g);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    if0.SS_n = 1'b1;
    if0.MOSI = 1'b0;
    if1.SS_n = 1'b1;
    if1.MOSI = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    test_write_burst;
    test_read_burst;
    test_abort;
    test_reset_mid_read;
    test_variant;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
